// File: rtl/sync_fifo_rr_sched.sv
// Round-robin read scheduler: drains N_SRC first-word-fall-through FIFOs into one
// registered valid/ready stream, granting each source up to BURST consecutive words.
module sync_fifo_rr_sched #(
    parameter int N_SRC  = 4,
    parameter int DWIDTH = 32,
    parameter int BURST  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          src_empty,
    input  logic [N_SRC*DWIDTH-1:0]   src_data,
    output logic [N_SRC-1:0]          src_rd_en,
    input  logic [N_SRC-1:0]          cfg_en,
    output logic [DWIDTH-1:0]         m_data,
    output logic [$clog2(N_SRC)-1:0]  m_src,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      busy
);

    localparam int IW = $clog2(N_SRC);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [IW:0] N_WIDE = (IW+1)'(N_SRC);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t            state_reg;
    logic [IW-1:0]     grant_reg;
    logic [IW-1:0]     last_grant_reg;
    logic [CW-1:0]     cnt_reg;
    logic [DWIDTH-1:0] m_data_reg;
    logic [IW-1:0]     m_src_reg;
    logic              m_valid_reg;

    logic [N_SRC-1:0]  eligible;
    logic [DWIDTH-1:0] src_word [N_SRC];
    logic [IW:0]       cand_sum  [N_SRC];
    logic [IW:0]       cand_wrap [N_SRC];
    logic [IW-1:0]     cand_idx  [N_SRC];
    logic [N_SRC-1:0]  cand_elig;
    logic [IW-1:0]     pick;
    logic              found;
    logic              load;
    logic              pop;

    assign load = ~m_valid_reg | m_ready;
    assign pop  = (state_reg == SERVE) & load & eligible[grant_reg];

    // Candidate gi is the source gi+1 places after the last grant, wrapped at N_SRC.
    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign eligible[gi]  = cfg_en[gi] & ~src_empty[gi];
            assign src_word[gi]  = src_data[gi*DWIDTH +: DWIDTH];
            assign src_rd_en[gi] = pop & (grant_reg == IW'(gi));
            assign cand_sum[gi]  = {1'b0, last_grant_reg} + (IW+1)'(gi + 1);
            assign cand_wrap[gi] = cand_sum[gi] - N_WIDE;
            assign cand_idx[gi]  = (cand_sum[gi] >= N_WIDE) ? cand_wrap[gi][IW-1:0]
                                                            : cand_sum[gi][IW-1:0];
            assign cand_elig[gi] = eligible[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (cand_elig[k]) pick = cand_idx[k];
        end
    end

    assign found = |cand_elig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IW'(N_SRC - 1);
            cnt_reg        <= '0;
            m_data_reg     <= '0;
            m_src_reg      <= '0;
            m_valid_reg    <= 1'b0;
        end else begin
            // A pop overwrites the word being accepted in the same edge.
            if (pop) begin
                m_data_reg  <= src_word[grant_reg];
                m_src_reg   <= grant_reg;
                m_valid_reg <= 1'b1;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (found) begin
                        grant_reg      <= pick;
                        last_grant_reg <= pick;
                        cnt_reg        <= '0;
                        state_reg      <= SERVE;
                    end
                end
                SERVE: begin
                    if (load) begin
                        if (eligible[grant_reg]) begin
                            cnt_reg <= cnt_reg + CW'(1);
                            if (cnt_reg == CW'(BURST - 1)) state_reg <= IDLE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_data  = m_data_reg;
    assign m_src   = m_src_reg;
    assign m_valid = m_valid_reg;
    assign busy    = (state_reg == SERVE) | m_valid_reg;

endmodule

// File: tb/tb_sync_fifo_rr_sched.sv
// Bench for sync_fifo_rr_sched: queue-based FIFO sources plus a cycle-level
// reference built from the grant/burst rules, checked every cycle.
module tb_sync_fifo_rr_sched;

    localparam int N  = 4;
    localparam int D  = 32;
    localparam int B  = 8;
    localparam int IW = $clog2(N);

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   src_empty;
    logic [N*D-1:0] src_data;
    logic [N-1:0]   src_rd_en;
    logic [N-1:0]   cfg_en;
    logic [D-1:0]   m_data;
    logic [IW-1:0]  m_src;
    logic           m_valid;
    logic           m_ready;
    logic           busy;

    sync_fifo_rr_sched #(.N_SRC(N), .DWIDTH(D), .BURST(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_empty (src_empty),
        .src_data  (src_data),
        .src_rd_en (src_rd_en),
        .cfg_en    (cfg_en),
        .m_data    (m_data),
        .m_src     (m_src),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [D-1:0] q [N][$];

    // Reference state: grant index (-1 = no grant), rotation pointer, words sent.
    int           ref_grant;
    int           ref_last;
    int           ref_cnt;
    bit           ref_valid;
    logic [D-1:0] ref_data;
    int           ref_src;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit elig(input int i);
        return cfg_en[i] && (q[i].size() > 0);
    endfunction

    task automatic ref_reset();
        ref_grant = -1;
        ref_last  = N - 1;
        ref_cnt   = 0;
        ref_valid = 1'b0;
        ref_data  = '0;
        ref_src   = 0;
    endtask

    task automatic step(input bit do_rst);
        logic [N-1:0] exp_rd;
        logic [N-1:0] rd_s;
        bit           load, pop, nvalid;
        int           ng, nlast, ncnt, nsrc, idx;
        logic [D-1:0] ndata;

        @(negedge clk);
        rst_n = !do_rst;
        for (int i = 0; i < N; i++) begin
            src_empty[i]       = (q[i].size() == 0);
            src_data[i*D +: D] = (q[i].size() > 0) ? q[i][0] : '0;
        end
        #1;
        load   = !ref_valid || m_ready;
        pop    = (ref_grant >= 0) && load && elig(ref_grant);
        exp_rd = '0;
        if (pop) exp_rd[ref_grant] = 1'b1;

        chk("rd_en",   64'(src_rd_en), 64'(exp_rd));
        chk("m_valid", 64'(m_valid),   64'(ref_valid));
        chk("m_data",  64'(m_data),    64'(ref_data));
        chk("m_src",   64'(m_src),     64'(ref_src));
        chk("busy",    64'(busy),      64'((ref_grant >= 0) || ref_valid));
        if (m_valid && m_ready && rst_n)
            $display("xfer src=%0d data=%08h", m_src, m_data);
        rd_s = src_rd_en;

        nvalid = ref_valid; ndata = ref_data; nsrc = ref_src;
        ng = ref_grant; nlast = ref_last; ncnt = ref_cnt;
        if (pop) begin
            nvalid = 1'b1;
            ndata  = q[ref_grant][0];
            nsrc   = ref_grant;
        end else if (m_ready) begin
            nvalid = 1'b0;
        end
        if (ref_grant < 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (ref_last + k) % N;
                if (ng < 0 && elig(idx)) begin
                    ng = idx; nlast = idx; ncnt = 0;
                end
            end
        end else if (load) begin
            if (elig(ref_grant)) begin
                ncnt = ref_cnt + 1;
                if (ncnt == B) ng = -1;
            end else begin
                ng = -1;
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (rd_s[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (do_rst) begin
            ref_reset();
        end else begin
            ref_grant = ng; ref_last = nlast; ref_cnt = ncnt;
            ref_valid = nvalid; ref_data = ndata; ref_src = nsrc;
        end
    endtask

    initial begin
        int total;
        int sel;

        rst_n     = 1'b0;
        m_ready   = 1'b0;
        cfg_en    = '1;
        src_empty = '1;
        src_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        ref_reset();

        // Single source holding three words, sink always ready.
        q[1].push_back(32'h0000_00A1);
        q[1].push_back(32'h0000_00A2);
        q[1].push_back(32'h0000_00A3);
        m_ready = 1'b1;
        repeat (8) step(1'b0);

        // All sources loaded with 20 words; a 5-cycle stall early in the first burst.
        for (int s = 0; s < N; s++)
            for (int w = 0; w < 20; w++)
                q[s].push_back(32'(s << 24) | 32'(w));
        for (int c = 0; c < 120; c++) begin
            m_ready = !(c >= 4 && c < 9);
            step(1'b0);
        end

        // Random traffic, backpressure, enable toggles and two mid-run resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (q[i].size() < 12 && $urandom_range(0, 99) < 20)
                    q[i].push_back($urandom);
            m_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 4) begin
                sel = int'($urandom_range(0, N - 1));
                cfg_en[sel] = ~cfg_en[sel];
            end
            step(c == 700 || c == 1200);
        end

        // Drain everything with all sources enabled.
        cfg_en  = '1;
        m_ready = 1'b1;
        repeat (250) step(1'b0);
        total = 0;
        for (int i = 0; i < N; i++) total += q[i].size();
        chk("drain_empty", 64'(total), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_rr_sched.md
# sync_fifo_rr_sched

Round-robin read scheduler that drains up to `N_SRC` first-word-fall-through synchronous FIFOs into one registered valid/ready output stream. Each granted source may send at most `BURST` consecutive words before the grant moves on. It sits downstream of a bank of `sync_fifo` instances and drives their `rd_en` inputs directly. Each FIFO's `rd_data` and `rd_empty` connect to this block's `src_data` and `src_empty`.

## Interface

**Parameters**

- `N_SRC`, default 4: number of source FIFOs, ≥2.
- `DWIDTH`, default 32: data width, matches the FIFOs.
- `BURST`, default 8: maximum words per grant, ≥1.

**Ports**

- `clk`, input, 1: the single clock, rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `src_empty`, input, `N_SRC`: per-FIFO `rd_empty`.
- `src_data`, input, `N_SRC*DWIDTH`: per-FIFO `rd_data`. Source i occupies bits `[i*DWIDTH +: DWIDTH]`.
- `src_rd_en`, output, `N_SRC`: per-FIFO pop, one-hot or zero.
- `cfg_en`, input, `N_SRC`: per-source enable mask. A disabled source is never granted.
- `m_data`, output, `DWIDTH`: output word.
- `m_src`, output, `$clog2(N_SRC)`: index of the source that supplied `m_data`.
- `m_valid`, output, 1: output word valid.
- `m_ready`, input, 1: downstream accept.
- `busy`, output, 1: high when the FSM is in SERVE or `m_valid` is high.

## Operation

**Core signals**

- `load = ~m_valid | m_ready`: the output register can take a word this cycle.
- `eligible[i] = cfg_en[i] & ~src_empty[i]`.

**FSM state IDLE**

- Search `eligible` round-robin, starting at `last_grant+1` and wrapping modulo `N_SRC`.
- If a source is found: set `grant` to it, set `last_grant` to it, clear `cnt`, and go to SERVE.
- If none is found: stay in IDLE.
- IDLE never pops a FIFO.

**FSM state SERVE**

- `pop = load & eligible[grant]`.
- `src_rd_en[grant] = pop`; all other bits are 0.
- On `pop`:
  - `m_data <= src_data[grant]`, `m_src <= grant`, `m_valid <= 1`.
  - `cnt <= cnt + 1`.
  - If `cnt == BURST-1`, go to IDLE.
- If `load & ~eligible[grant]` (source drained or disabled), go to IDLE with no pop.
- If `~load`, hold state, `cnt` and all outputs.

**Output register**

- When `m_ready & m_valid` and there is no `pop` in the same cycle, `m_valid <= 0`.
- On a `pop`, the new word replaces the accepted one in the same edge, so a word is never lost or duplicated.

**Width rules**

- `cnt` is `$clog2(BURST+1)` bits.
- `grant` and `last_grant` are `$clog2(N_SRC)` bits.
- Round-robin index arithmetic wraps explicitly at `N_SRC`, including for non-power-of-two `N_SRC`.

**Reset values** (reset takes priority over every other event)

- state = IDLE.
- `m_valid` = 0, `m_data` = 0, `m_src` = 0.
- `cnt` = 0, `grant` = 0.
- `last_grant = N_SRC-1`, so the first grant goes to source 0.
- `src_rd_en` = 0 and `busy` = 0 in the first cycle after reset.

## Timing

- `src_rd_en` is combinational from state, `grant`, `m_valid`, `m_ready`, `src_empty` and `cfg_en`. The FIFO pops at the same edge that `m_data` captures `src_data`, which relies on FIFO first-word-fall-through behaviour.
- Latency: a source becoming eligible while IDLE gives a grant on the next edge. The first word appears on `m_data`/`m_valid` one edge after that, 2 cycles minimum.
- Steady state: 1 word per cycle while `m_ready` is high.
- Exactly one bubble cycle (IDLE) separates consecutive grants.
- `cfg_en` deasserted during SERVE takes effect at the next `load` cycle. A word already in `m_data` is still delivered.
- A FIFO going empty mid-burst ends the grant; `cnt` does not carry over.
- Under `m_ready` low, `m_data`, `m_src` and `m_valid` are stable, which is the AXI-style rule that valid, once high, holds until accepted.
- Reset mid-burst: `m_valid` is low on the cycle after the reset edge and any held word is dropped. The FIFOs are reset separately.

## Test plan

1. **Single source drains:** after reset, only src1 holds A1–A3, `m_ready=1` → one grant cycle, then A1, A2, A3 on consecutive cycles with `m_src=1`; FSM returns to IDLE and `busy` goes to 0 one cycle after A3 is accepted.
2. **Burst rotation:** all 4 sources hold 20 words, `BURST=8` → output order src0×8, src1×8, src2×8, src3×8, src0×8, … with exactly one bubble between bursts; sources with 4 words left send a short final grant.
3. **Backpressure:** `m_ready=0` for 5 cycles during word 3 of a burst → `m_data`, `m_src`, `m_valid` held, `src_rd_en=0`; on resume the sequence continues with no loss or duplication and `cnt` is unaffected.
4. **Enable mask:** drop `cfg_en[2]` mid-burst of src2 → the word already in the output register is delivered, no further src2 pops, and src2 is skipped in rotation until re-enabled.
5. **Wrap-around:** `last_grant=3`, only src0 and src3 eligible → next grant is src0, then src3.
6. **Reset mid-operation:** `rst_n=0` for 1 cycle with `m_valid=1` → `m_valid=0` next cycle; the next grant is src0 regardless of the previous `last_grant`.
